mdu: RTL and testbench
======================

Name: mdu

Overview:
- Iterative integer multiply/divide unit in the EX stage of the 5-stage pipeline.
- Consumes operands from the ID/EX pipeline register and holds results in architectural HI/LO registers.
- Drives the stall that holds the enables of the upstream pipeline registers low while an operation is in flight.
- Radix-2 shift-add multiply and restoring divide; one bit per cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and at least 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous reset, active-low; asserting it forces reset state immediately
- start  input  1  launch an operation; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  WIDTH  rs operand / dividend
- b  input  WIDTH  rt operand / divisor
- abort  input  1  pipeline flush; cancels an in-flight operation
- mthi  input  1  write wdata into HI; honoured only in IDLE
- mtlo  input  1  write wdata into LO; honoured only in IDLE
- wdata  input  WIDTH  data for mthi/mtlo
- busy  output  1  operation in flight
- stall  output  1  combinational: busy | (start & idle); feeds enables of upstream pipeline registers
- done  output  1  one-cycle pulse when HI/LO take a new result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst low): state IDLE; busy, done and all datapath registers 0; hi = 0; lo = 0.
- States: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on start with op[1] = 0.
  - IDLE -> DIV on start with op[1] = 1.
  - MUL or DIV -> FIX when the iteration counter reaches WIDTH-1.
  - FIX -> IDLE unconditionally.
- Start edge:
  - Latches magnitudes of a and b: abs value for signed ops, raw value for unsigned ops.
  - Latches sign_q = a_msb ^ b_msb and sign_r = a_msb (signed ops only; 0 for unsigned).
  - Clears the counter.
- MUL, per cycle:
  - If multiplier LSB = 1, add multiplicand to the upper half of the 2*WIDTH accumulator.
  - Shift the accumulator right by 1, keeping the carry.
- DIV, per cycle:
  - Shift {rem, quo} left by 1, then trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set the quotient LSB.
- FIX, negation rules:
  - MULT: negate the full 2*WIDTH product if sign_q.
  - DIV: negate the quotient if sign_q; negate the remainder if sign_r.
- FIX, writeback:
  - hi <= upper half (MUL) or remainder (DIV).
  - lo <= lower half (MUL) or quotient (DIV).
  - done = 1 for the cycle following the FIX edge.
- Latency:
  - start sampled at edge T.
  - busy = 1 for the cycles after edges T .. T+WIDTH.
  - hi/lo are valid, and done = 1, in the cycle after edge T+WIDTH+1.
  - busy is 0 in that same cycle.
  - Total is WIDTH+1 busy cycles.
- Divide by zero: no trap. Results follow the restoring algorithm, which gives quotient all-ones and remainder = |a|; then the FIX sign rules apply. The bench checks exactly this.
- DIV of most-negative by -1: lo = 1 followed by WIDTH-1 zeros, i.e. most-negative; hi = 0. No exception.
- start while busy: ignored. The stall guarantees ID/EX holds the instruction; no re-launch.
- mthi/mtlo:
  - In IDLE: write on the edge.
  - While busy: ignored.
  - Same edge as start: the write takes effect and the operation launches. The result later overwrites HI/LO.
- abort:
  - In MUL/DIV/FIX: return to IDLE next edge; hi/lo unchanged; no done.
  - In IDLE: ignored. abort wins over start in the same cycle.
- Reset asserted mid-operation: immediate return to reset state; a partial result is never written.

Decomposition:
- Shared pipeline package holds:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV;
  - state encodings;
  - default WIDTH.
- One sub-module: mdu_negate, a combinational conditional two's-complement of a parameterised width. It is instantiated for the 2*WIDTH product and for each WIDTH quotient/remainder.
- Counter, FSM and datapath stay in mdu.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 busy cycles hi=0xFFFFFFFE, lo=0x00000001, done pulse.
- MULT a=-3 (0xFFFFFFFD), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high from the start cycle through the last busy cycle.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Launch MULTU 5*6, assert abort in busy cycle 10 -> busy low next cycle, no done, hi/lo keep the prior values. A following mtlo 0x1234 in IDLE -> lo=0x1234.
- Launch DIVU, pull rst low in busy cycle 20 -> hi=lo=0 and busy=0 immediately. After release, start is honoured normally; a second start asserted while busy is ignored.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit:
// operation and state encodings plus the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_FIX  = 2'b11
  } state_e;

endpackage

// File: rtl/mdu_negate.sv
// Combinational conditional two's complement: dout = en ? -din : din.
module mdu_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = en ? ('0 - din) : din;

endmodule

// File: rtl/mdu.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO registers.
// One bit per cycle; signs are stripped at launch and reapplied in FIX.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e             state, state_nxt;
  op_e                op_s;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic               sign_q, sign_r, is_div;

  logic               idle, launch, last, op_signed, op_div, writeback;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_s      = op_e'(op);
  assign op_signed = (op_s == OP_MULT) || (op_s == OP_DIV);
  assign op_div    = (op_s == OP_DIVU) || (op_s == OP_DIV);
  assign idle      = (state == S_IDLE);
  assign launch    = idle && start && !abort;
  assign last      = (cnt == CW'(WIDTH - 1));
  assign writeback = (state == S_FIX) && !abort;

  assign mag_a = (op_signed && a[WIDTH-1]) ? ('0 - a) : a;
  assign mag_b = (op_signed && b[WIDTH-1]) ? ('0 - b) : b;

  // Multiply: acc = {partial product, remaining multiplier bits}; the carry
  // out of the add is shifted back in so no product bit is lost.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : '0)};
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {rem, quo}. The shifted remainder needs WIDTH+1 bits; when
  // it is >= divisor the low WIDTH bits of the difference are exact.
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign div_ge   = (rem_sh >= {1'b0, opd});
  assign div_diff = rem_sh[WIDTH-1:0] - opd;
  assign div_nxt  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  mdu_negate #(.W(2*WIDTH)) u_neg_prod (
    .en(sign_q), .din(acc), .dout(prod_fix)
  );
  mdu_negate #(.W(WIDTH)) u_neg_quo (
    .en(sign_q), .din(acc[WIDTH-1:0]), .dout(quo_fix)
  );
  mdu_negate #(.W(WIDTH)) u_neg_rem (
    .en(sign_r), .din(acc[2*WIDTH-1:WIDTH]), .dout(rem_fix)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: assigning a default first keeps every path driven, so no latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (launch) state_nxt = op_div ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (abort) state_nxt = S_IDLE;
                    else if (last) state_nxt = S_FIX;
      S_FIX:        state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = !idle;
    stall = busy || (start && idle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      opd    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        cnt    <= '0;
        acc    <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
        opd    <= op_div ? mag_b : mag_a;
        sign_q <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        sign_r <= op_signed && a[WIDTH-1];
        is_div <= op_div;
      end else if (state == S_MUL || state == S_DIV) begin
        cnt <= cnt + CW'(1);
        acc <= (state == S_DIV) ? div_nxt : mul_nxt;
      end
      // Move-to writes land in IDLE even on a launch edge; the result of that
      // operation overwrites them later.
      if (idle && mthi) hi <= wdata;
      if (idle && mtlo) lo <= wdata;
      if (writeback) begin
        hi   <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo   <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: results are queued when an operation is launched
// and popped when the done pulse appears.
module tb_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] cur_hi, cur_lo;

  mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    longint      sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   p = {32'b0, x} * {32'b0, y};
      2'b01:   p = sx * sy;
      2'b10:   p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) begin
          q = (sx < 0) ? 1 : -1;
          r = sx;
        end else begin
          q = sx / sy;
          r = sx % sy;
        end
        p = {r[31:0], q[31:0]};
      end
    endcase
    return p;
  endfunction

  // Launch one operation and follow it to its done pulse. With hold set, a
  // conflicting start (MULTU 3*3) is kept asserted for the first busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [63:0] exp, input string tag, input bit hold);
    int   nbusy;
    bit   seen;
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back('{hi: exp[63:32], lo: exp[31:0], tag: tag});
    #1 check({tag, "_stall_launch"}, stall, 1);
    nbusy = 0;
    seen  = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (hold && nbusy < 5) begin
        start = 1'b1; op = 2'b00; a = 3; b = 3;
      end else begin
        start = 1'b0;
      end
      if (busy) begin
        nbusy++;
        check({tag, "_stall_busy"}, stall, 1);
      end
      if (done) begin
        seen = 1;
        e = sb.pop_front();
        check({e.tag, "_hi"}, hi, e.hi);
        check({e.tag, "_lo"}, lo, e.lo);
        check({e.tag, "_busy_cycles"}, nbusy, W + 1);
        check({e.tag, "_busy_at_done"}, busy, 0);
        cur_hi = e.hi;
        cur_lo = e.lo;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
    check({tag, "_done_single"}, done, 0);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    bit           any_done;

    rst = 1'b0; start = 1'b0; abort = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    cur_hi = '0; cur_lo = '0;

    #12;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_stall", stall, 0);
    @(negedge clk) rst = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max", 0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "mult_neg", 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg", 0);
    run_op(2'b10, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, "divu_zero", 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_minneg", 0);
    run_op(2'b11, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, "div_zero_pos", 0);

    for (int k = 0; k < 4; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d", k), 0);
    end

    // Abort in busy cycle 10.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 5; b = 6;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy_after", busy, 0);
    any_done = done;
    repeat (40) begin
      @(posedge clk); #1;
      any_done = any_done | done;
    end
    check("abort_no_done", any_done, 0);
    check("abort_hi", hi, cur_hi);
    check("abort_lo", lo, cur_lo);

    mtlo = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_hi", hi, cur_hi);
    cur_lo = 32'h1234;

    // Reset pulled in busy cycle 20.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = 100; b = 7;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("rstmid_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("rstmid_hi", hi, 0);
    check("rstmid_lo", lo, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    @(negedge clk) rst = 1'b1;
    cur_hi = '0; cur_lo = '0;

    run_op(2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "divu_after_rst", 1);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
